// File: rtl/adpll_chan_seq.sv
// adpll_chan_seq: channel sequencer in front of the ADPLL control core.
// Takes channel-change requests, programs FCW/mode, supervises lock with a
// timeout, and restarts the core through a PD window on each timeout.
// Optional build macro ADPLL_CHAN_SEQ_STATS_EN adds lock_cycles/fail_count.
module adpll_chan_seq #(
  parameter int unsigned FCWW       = 26,
  parameter int unsigned CHW        = 6,
  parameter int unsigned TOW        = 12,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned PD_CYC     = 4,
  parameter int unsigned LOCK_BLANK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            abort,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CHW-1:0]  req_chan,
  input  logic [1:0]      req_mode,
  input  logic [FCWW-1:0] fcw_base,
  input  logic [15:0]     fcw_step,
  input  logic [TOW-1:0]  lock_timeout,
  input  logic            channel_lock,
  output logic [FCWW-1:0] fcw,
  output logic [1:0]      adpll_mode,
  output logic            busy,
  output logic            done,
  output logic            fail,
  output logic            lost_lock,
  output logic [CHW-1:0]  cur_chan,
  output logic [1:0]      retry_cnt
`ifdef ADPLL_CHAN_SEQ_STATS_EN
  ,
  output logic [15:0]     lock_cycles,
  output logic [7:0]      fail_count
`endif
);

  localparam int unsigned PW = CHW + 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_RETRY  = 3'd4;

  localparam logic [1:0] M_PD   = 2'd0;
  localparam logic [1:0] M_RX   = 2'd2;
  localparam logic [1:0] M_TX   = 2'd3;

  localparam logic [TOW-1:0] TIMER_MAX = '1;
  localparam logic [TOW-1:0] BLANK     = TOW'(LOCK_BLANK);
  localparam logic [TOW-1:0] PD_LAST   = TOW'(PD_CYC - 1);
  localparam logic [1:0]     RETRY_LIM = 2'(MAX_RETRY);

  logic [2:0]      state, state_nx;
  logic [TOW-1:0]  timer, timer_nx;
  logic [1:0]      mode_lat, mode_lat_nx;
  logic [FCWW-1:0] fcw_nx;
  logic [1:0]      mode_nx;
  logic            busy_nx, done_nx, fail_nx, lost_nx;
  logic [CHW-1:0]  cur_chan_nx;
  logic [1:0]      retry_nx;
  logic [PW-1:0]   prod;
  logic [FCWW-1:0] fcw_calc;
  logic            accept;
  logic            seq_active;

  // Ready only while no sequence is running; forced low during reset.
  assign req_ready = ((state == S_IDLE) || (state == S_LOCKED)) & ~rst;

  // Next-state and next-output logic; en=0 holds everything but pulses.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    mode_lat_nx = mode_lat;
    fcw_nx      = fcw;
    mode_nx     = adpll_mode;
    busy_nx     = busy;
    cur_chan_nx = cur_chan;
    retry_nx    = retry_cnt;
    done_nx     = 1'b0;
    fail_nx     = 1'b0;
    lost_nx     = 1'b0;
    prod        = PW'(req_chan) * PW'(fcw_step);
    fcw_calc    = fcw_base + FCWW'(prod);
    accept      = req_valid & req_ready;
    seq_active  = (state == S_APPLY) || (state == S_WAIT) || (state == S_RETRY);

    if (en) begin
      if (seq_active && abort) begin
        mode_nx  = M_PD;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_LOCKED: begin
            if (accept) begin
              case (req_mode)
                M_RX, M_TX: begin
                  fcw_nx      = fcw_calc;
                  mode_nx     = req_mode;
                  mode_lat_nx = req_mode;
                  cur_chan_nx = req_chan;
                  retry_nx    = 2'd0;
                  busy_nx     = 1'b1;
                  state_nx    = S_APPLY;
                end
                M_PD: begin
                  mode_nx  = M_PD;
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
                end
                default: begin
                  // TEST is not a tunable mode: reject without side effects.
                  fail_nx = 1'b1;
                end
              endcase
            end else if ((state == S_LOCKED) && !channel_lock) begin
              // Relock on the same channel without touching the mode.
              lost_nx  = 1'b1;
              retry_nx = 2'd0;
              busy_nx  = 1'b1;
              state_nx = S_APPLY;
            end
          end
          S_APPLY: begin
            timer_nx = '0;
            state_nx = S_WAIT;
          end
          S_WAIT: begin
            timer_nx = (timer == TIMER_MAX) ? timer : timer + TOW'(1);
            if ((timer >= BLANK) && channel_lock) begin
              done_nx  = 1'b1;
              busy_nx  = 1'b0;
              state_nx = S_LOCKED;
            end else if ((lock_timeout != '0) && (timer == lock_timeout)) begin
              mode_nx = M_PD;
              if (retry_cnt < RETRY_LIM) begin
                retry_nx = retry_cnt + 2'd1;
                timer_nx = '0;
                state_nx = S_RETRY;
              end else begin
                fail_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
              end
            end
          end
          S_RETRY: begin
            // Timer doubles as the PD window counter; restoring the mode
            // makes the core restart its frequency search.
            if (timer == PD_LAST) begin
              mode_nx  = mode_lat;
              state_nx = S_APPLY;
            end else begin
              timer_nx = timer + TOW'(1);
            end
          end
          default: begin
            mode_nx  = M_PD;
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
          end
        endcase
      end
    end
  end

  // State and registered outputs, updated on the core's negedge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      mode_lat   <= M_PD;
      fcw        <= '0;
      adpll_mode <= M_PD;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      lost_lock  <= 1'b0;
      cur_chan   <= '0;
      retry_cnt  <= 2'd0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      mode_lat   <= mode_lat_nx;
      fcw        <= fcw_nx;
      adpll_mode <= mode_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      fail       <= fail_nx;
      lost_lock  <= lost_nx;
      cur_chan   <= cur_chan_nx;
      retry_cnt  <= retry_nx;
    end
  end

`ifdef ADPLL_CHAN_SEQ_STATS_EN
  logic [15:0] seq_cyc, seq_cyc_nx, lock_cycles_nx;
  logic [7:0]  fail_count_nx;

  // Lock time counts edges from the APPLY edge through the locking edge.
  always_comb begin
    seq_cyc_nx     = seq_cyc;
    lock_cycles_nx = lock_cycles;
    fail_count_nx  = fail_count;
    if (en && !(seq_active && abort)) begin
      if (state == S_APPLY) begin
        seq_cyc_nx = 16'd1;
      end else if (state == S_WAIT) begin
        if (state_nx == S_LOCKED) begin
          lock_cycles_nx = (seq_cyc == 16'hFFFF) ? seq_cyc : seq_cyc + 16'd1;
        end else begin
          seq_cyc_nx = (seq_cyc == 16'hFFFF) ? seq_cyc : seq_cyc + 16'd1;
        end
      end
    end
    if (fail_nx && (fail_count != 8'hFF)) begin
      fail_count_nx = fail_count + 8'd1;
    end
  end

  // Statistics registers.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      seq_cyc     <= '0;
      lock_cycles <= '0;
      fail_count  <= '0;
    end else begin
      seq_cyc     <= seq_cyc_nx;
      lock_cycles <= lock_cycles_nx;
      fail_count  <= fail_count_nx;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
